// File: rtl/id_branch_stage_if.sv
// ---------------------------------------------------------------------------
// id_branch_stage_if
//
// Purpose:
//   Fetch <-> decode link. Fetch presents the next instruction and its address.
//   Decode answers with a redirect request and the redirect target.
//
// Signals:
//   if_IR            fetch -> decode   instruction word, stable at posedge
//   if_PC            fetch -> decode   address of if_IR
//   is_Branch_Taken  decode -> fetch   redirect request (combinational)
//   branchPC         decode -> fetch   redirect target, 0 when no redirect
//
// Modports:
//   master  the fetch stage (drives the instruction)
//   slave   the decode stage (drives the redirect)
// ---------------------------------------------------------------------------
interface id_branch_stage_if;

    logic [31:0] if_IR;
    logic [31:0] if_PC;
    logic        is_Branch_Taken;
    logic [31:0] branchPC;

    modport master (
        output if_IR,
        output if_PC,
        input  is_Branch_Taken,
        input  branchPC
    );

    modport slave (
        input  if_IR,
        input  if_PC,
        output is_Branch_Taken,
        output branchPC
    );

endinterface

// File: rtl/id_branch_stage.sv
// ---------------------------------------------------------------------------
// id_branch_stage
//
// Purpose:
//   This is the IF/ID pipeline register, with early branch resolution in
//   decode. It handles BEQ, BNE and J. When the instruction in ID redirects
//   fetch, the one wrong-path instruction already fetched behind it is
//   captured as a bubble (id_valid = 0). The block also supports a hazard
//   stall and an external flush. Two saturating counters record taken
//   redirects and squashed slots.
//
// Ports:
//   clk           clock; all state updates on posedge
//   reset         asynchronous, active-low reset
//   fetch         slave side of id_branch_stage_if (if_IR/if_PC in,
//                 is_Branch_Taken/branchPC out)
//   stall         hazard stall: hold ID contents, suppress redirect
//   flush         external flush: invalidate ID contents
//   rs_data       register-file value for id_IR[25:21]
//   rt_data       register-file value for id_IR[20:16]
//   id_IR, id_PC  latched instruction and its address
//   id_valid      ID holds a real (not squashed/flushed) instruction
//   taken_count   redirects issued, saturating
//   squash_count  wrong-path instructions squashed, saturating
// ---------------------------------------------------------------------------
module id_branch_stage #(
    parameter int          CNT_W   = 16,
    parameter logic [5:0]  OPC_BEQ = 6'h04,
    parameter logic [5:0]  OPC_BNE = 6'h05,
    parameter logic [5:0]  OPC_J   = 6'h02
) (
    input  logic               clk,
    input  logic               reset,
    id_branch_stage_if.slave   fetch,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic [31:0]        id_IR,
    output logic [31:0]        id_PC,
    output logic               id_valid,
    output logic [CNT_W-1:0]   taken_count,
    output logic [CNT_W-1:0]   squash_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic [31:0] pc4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic        cond_met;
    logic        take;
    logic [31:0] target;

    assign opcode = id_IR[31:26];
    assign imm16  = id_IR[15:0];

    // Branch and jump targets are computed from the ID registers only.
    // The word offset is sign-extended and then scaled by 4. The addition
    // wraps modulo 2^32, so a backward branch at a low PC can wrap around.
    assign pc4       = id_PC + 32'd4;
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target = pc4 + br_offset;
    assign j_target  = {pc4[31:28], id_IR[25:0], 2'b00};

    // Resolve the instruction held in ID. A squashed or flushed slot has
    // id_valid = 0, so it never redirects, even if it encodes a branch. For
    // this reason back-to-back branches redirect only once. A stalled branch
    // waits, and it resolves with the operands that are present in the first
    // cycle without a stall.
    always_comb begin
        is_beq   = (opcode == OPC_BEQ);
        is_bne   = (opcode == OPC_BNE);
        is_j     = (opcode == OPC_J);
        cond_met = 1'b0;
        target   = 32'h0;

        if (is_j) begin
            cond_met = 1'b1;
            target   = j_target;
        end else if (is_beq) begin
            cond_met = (rs_data == rt_data);
            target   = br_target;
        end else if (is_bne) begin
            cond_met = (rs_data != rt_data);
            target   = br_target;
        end

        take = id_valid & ~stall & cond_met;
    end

    // The redirect outputs are zero when there is no redirect, so fetch never
    // sees a stale target. During reset id_valid is 0, so both outputs are 0.
    assign fetch.is_Branch_Taken = take;
    assign fetch.branchPC        = take ? target : 32'h0;

    // The ID register priority is flush > stall > take > normal.
    // On take, the instruction arriving from fetch is the wrong-path slot.
    // That slot is captured as a bubble, so ID still tracks if_PC, and the
    // redirected target becomes valid one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_IR    <= 32'h0;
            id_PC    <= 32'h0;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_IR    <= 32'h0;
            id_PC    <= fetch.if_PC;
            id_valid <= 1'b0;
        end else if (stall) begin
            id_IR    <= id_IR;
            id_PC    <= id_PC;
            id_valid <= id_valid;
        end else begin
            id_IR    <= fetch.if_IR;
            id_PC    <= fetch.if_PC;
            id_valid <= ~take;
        end
    end

    // Each redirect squashes exactly one slot, so both counters step
    // together. Each counter stops at all-ones. A flush on the same edge
    // cancels the redirect, and then neither counter changes. A stall
    // suppresses the redirect, so a stall needs no separate term here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_count  <= '0;
            squash_count <= '0;
        end else if (take && !flush) begin
            if (taken_count != CNT_MAX) begin
                taken_count <= taken_count + CNT_ONE;
            end
            if (squash_count != CNT_MAX) begin
                squash_count <= squash_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_branch_stage.sv
// ---------------------------------------------------------------------------
// tb_id_branch_stage
//
// Purpose:
//   Directed bench for id_branch_stage. A behavioural model predicts every
//   output. It uses plain arithmetic on the instruction fields. A compare
//   process checks the model against the DUT on every falling edge. Literal
//   expectations, computed by hand, fix the model to known answers.
//   A second instance with 8-bit counters exercises saturation in a few
//   hundred cycles.
// ---------------------------------------------------------------------------
module tb_id_branch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic [31:0] id_ir;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [15:0] taken_count;
    logic [15:0] squash_count;

    logic [31:0] sat_id_ir;
    logic [31:0] sat_id_pc;
    logic        sat_id_valid;
    logic [7:0]  sat_taken_count;
    logic [7:0]  sat_squash_count;

    int check_count = 0;
    int error_count = 0;

    // Model state and temporaries
    logic [31:0] m_ir     = 32'h0;
    logic [31:0] m_pc     = 32'h0;
    logic        m_valid  = 1'b0;
    int          m_taken  = 0;
    int          m_squash = 0;
    logic        m_tk;
    logic [31:0] m_tgt;

    id_branch_stage_if fetch_bus ();
    id_branch_stage_if fetch_bus_sat ();

    assign fetch_bus.if_IR     = if_ir;
    assign fetch_bus.if_PC     = if_pc;
    assign fetch_bus_sat.if_IR = if_ir;
    assign fetch_bus_sat.if_PC = if_pc;

    id_branch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .fetch        (fetch_bus),
        .stall        (stall),
        .flush        (flush),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .id_IR        (id_ir),
        .id_PC        (id_pc),
        .id_valid     (id_valid),
        .taken_count  (taken_count),
        .squash_count (squash_count)
    );

    id_branch_stage #(.CNT_W(8)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .fetch        (fetch_bus_sat),
        .stall        (stall),
        .flush        (flush),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .id_IR        (sat_id_ir),
        .id_PC        (sat_id_pc),
        .id_valid     (sat_id_valid),
        .taken_count  (sat_taken_count),
        .squash_count (sat_squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decide from the instruction fields whether the instruction redirects
    // fetch, and to which address.
    function automatic void predict(input logic [31:0] ir, input logic [31:0] pc,
                                    input logic valid, input logic st,
                                    input logic [31:0] rs, input logic [31:0] rt,
                                    output logic tk, output logic [31:0] tgt);
        int   off;
        logic hit;
        off = $signed(ir[15:0]);
        hit = 1'b0;
        tgt = 32'h0;
        if (ir[31:26] == 6'h02) begin
            hit = 1'b1;
            tgt = ((pc + 32'd4) & 32'hF000_0000) | ({6'b0, ir[25:0]} * 32'd4);
        end else if (ir[31:26] == 6'h04 || ir[31:26] == 6'h05) begin
            hit = (ir[31:26] == 6'h04) ? (rs == rt) : (rs != rt);
            tgt = pc + 32'd4 + 32'(off * 4);
        end
        tk = valid && !st && hit;
        if (!tk) tgt = 32'h0;
    endfunction

    function automatic logic [31:0] sat_val(input int count, input int width);
        int max_val;
        max_val = (1 << width) - 1;
        return (count > max_val) ? 32'(max_val) : 32'(count);
    endfunction

    // Track the contents of ID and the unsaturated redirect totals.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ir     = 32'h0;
            m_pc     = 32'h0;
            m_valid  = 1'b0;
            m_taken  = 0;
            m_squash = 0;
        end else begin
            predict(m_ir, m_pc, m_valid, stall, rs_data, rt_data, m_tk, m_tgt);
            if (flush) begin
                m_ir    = 32'h0;
                m_pc    = if_pc;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_ir    = if_ir;
                m_pc    = if_pc;
                m_valid = !m_tk;
                if (m_tk) begin
                    m_taken  = m_taken + 1;
                    m_squash = m_squash + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count = check_count + 1;
        if (actual !== expected) begin
            error_count = error_count + 1;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Compare both DUTs against the model in the middle of every cycle.
    always @(negedge clk) begin : compare_proc
        logic        c_tk;
        logic [31:0] c_tgt;
        predict(m_ir, m_pc, m_valid, stall, rs_data, rt_data, c_tk, c_tgt);
        checkOutput("cyc_taken",   {31'b0, fetch_bus.is_Branch_Taken}, {31'b0, c_tk});
        checkOutput("cyc_target",  fetch_bus.branchPC, c_tgt);
        checkOutput("cyc_id_ir",   id_ir, m_ir);
        checkOutput("cyc_id_pc",   id_pc, m_pc);
        checkOutput("cyc_valid",   {31'b0, id_valid}, {31'b0, m_valid});
        checkOutput("cyc_tcount",  {16'b0, taken_count}, sat_val(m_taken, 16));
        checkOutput("cyc_scount",  {16'b0, squash_count}, sat_val(m_squash, 16));
        checkOutput("sat_taken",   {31'b0, fetch_bus_sat.is_Branch_Taken}, {31'b0, c_tk});
        checkOutput("sat_valid",   {31'b0, sat_id_valid}, {31'b0, m_valid});
        checkOutput("sat_tcount",  {24'b0, sat_taken_count}, sat_val(m_taken, 8));
        checkOutput("sat_scount",  {24'b0, sat_squash_count}, sat_val(m_squash, 8));
    end

    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] pc,
                                 input logic st, input logic fl,
                                 input logic [31:0] rs, input logic [31:0] rt);
        if_ir   = ir;
        if_pc   = pc;
        stall   = st;
        flush   = fl;
        rs_data = rs;
        rt_data = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset is held across clock edges.
        repeat (3) tick();
        checkOutput("rst_valid",  {31'b0, id_valid}, 32'h0);
        checkOutput("rst_ir",     id_ir, 32'h0);
        checkOutput("rst_taken",  {31'b0, fetch_bus.is_Branch_Taken}, 32'h0);
        checkOutput("rst_tcount", {16'b0, taken_count}, 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("rel_ir",    id_ir, 32'hDEAD_BEEF);
        checkOutput("rel_valid", {31'b0, id_valid}, 32'h1);

        // BEQ taken: 0x1000_0003 at 0x10, rs == rt
        applyStimulus(32'h1000_0003, 32'h10, 1'b0, 1'b0, 32'd5, 32'd5);
        tick();
        applyStimulus(32'h0000_0000, 32'h14, 1'b0, 1'b0, 32'd5, 32'd5);
        checkOutput("beq_taken",  {31'b0, fetch_bus.is_Branch_Taken}, 32'h1);
        checkOutput("beq_target", fetch_bus.branchPC, 32'h20);
        tick();
        checkOutput("beq_squash", {31'b0, id_valid}, 32'h0);
        checkOutput("beq_tcount", {16'b0, taken_count}, 32'd1);
        checkOutput("beq_scount", {16'b0, squash_count}, 32'd1);

        // BNE backward: 0x1400_FFFF at 0x100, taken with rs != rt
        applyStimulus(32'h1400_FFFF, 32'h100, 1'b0, 1'b0, 32'd1, 32'd2);
        tick();
        applyStimulus(32'h0000_0000, 32'h104, 1'b0, 1'b0, 32'd1, 32'd2);
        checkOutput("bne_target", fetch_bus.branchPC, 32'h100);
        applyStimulus(32'h0000_0000, 32'h104, 1'b0, 1'b0, 32'd2, 32'd2);
        checkOutput("bne_nt",     {31'b0, fetch_bus.is_Branch_Taken}, 32'h0);
        checkOutput("bne_nt_pc",  fetch_bus.branchPC, 32'h0);
        tick();
        checkOutput("bne_next_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("bne_tcount", {16'b0, taken_count}, 32'd1);

        // Jump at 0x40; the squashed slot behind it is also a J.
        applyStimulus(32'h0800_0020, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        applyStimulus(32'h0800_0030, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("j_target", fetch_bus.branchPC, 32'h80);
        tick();
        applyStimulus(32'h0000_0000, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("j_slot_nt", {31'b0, fetch_bus.is_Branch_Taken}, 32'h0);
        tick();
        checkOutput("j_land_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("j_tcount", {16'b0, taken_count}, 32'd2);

        // A stall holds a taken BEQ for 3 cycles; the redirect fires when the stall drops.
        applyStimulus(32'h1000_0003, 32'h10, 1'b0, 1'b0, 32'd5, 32'd5);
        tick();
        applyStimulus(32'h0000_0000, 32'h14, 1'b1, 1'b0, 32'd5, 32'd5);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_nt", {31'b0, fetch_bus.is_Branch_Taken}, 32'h0);
            tick();
            checkOutput("stall_hold_ir", id_ir, 32'h1000_0003);
            checkOutput("stall_hold_valid", {31'b0, id_valid}, 32'h1);
        end
        applyStimulus(32'h0000_0000, 32'h14, 1'b0, 1'b0, 32'd5, 32'd5);
        checkOutput("unstall_taken",  {31'b0, fetch_bus.is_Branch_Taken}, 32'h1);
        checkOutput("unstall_target", fetch_bus.branchPC, 32'h20);
        tick();
        checkOutput("unstall_tcount", {16'b0, taken_count}, 32'd3);

        // Flush and stall together: the flush wins.
        applyStimulus(32'h0000_0000, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        applyStimulus(32'h0000_0000, 32'h24, 1'b1, 1'b1, 32'd0, 32'd0);
        tick();
        checkOutput("flst_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("flst_pc",    id_pc, 32'h24);

        // A flush on the same edge as a taken branch: no count.
        applyStimulus(32'h1000_0003, 32'h10, 1'b0, 1'b0, 32'd7, 32'd7);
        tick();
        applyStimulus(32'h0000_0000, 32'h14, 1'b0, 1'b1, 32'd7, 32'd7);
        tick();
        checkOutput("fltk_valid",  {31'b0, id_valid}, 32'h0);
        checkOutput("fltk_tcount", {16'b0, taken_count}, 32'd3);

        // Saturation: a stream of jumps redirects on every second edge.
        applyStimulus(32'h0800_0020, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (600) tick();
        checkOutput("sat_full",   {24'b0, sat_taken_count}, 32'hFF);
        checkOutput("wide_count", {16'b0, taken_count}, 32'd303);
        repeat (2) tick();
        checkOutput("sat_hold",    {24'b0, sat_taken_count}, 32'hFF);
        checkOutput("sat_sq_hold", {24'b0, sat_squash_count}, 32'hFF);
        checkOutput("wide_count2", {16'b0, taken_count}, 32'd304);

        // Async reset in the middle of a cycle, with no clock edge.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_sat",    {24'b0, sat_taken_count}, 32'h0);
        checkOutput("arst_tcount", {16'b0, taken_count}, 32'h0);
        checkOutput("arst_valid",  {31'b0, id_valid}, 32'h0);
        checkOutput("arst_taken",  {31'b0, fetch_bus.is_Branch_Taken}, 32'h0);
        tick();
        reset = 1'b1;
        applyStimulus(32'h0000_0020, 32'h200, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        checkOutput("post_rst_ir",    id_ir, 32'h0000_0020);
        checkOutput("post_rst_valid", {31'b0, id_valid}, 32'h1);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
